pipeline_ctrl_gen: RTL

//  Parametrised pipeline controller: merges per-stage stall requests into a thermometer stall vector.

---
 rtl/pipeline_ctrl_gen_pkg.sv | 34 +++
 rtl/pipeline_ctrl_gen_if.sv | 29 ++
 rtl/pipeline_ctrl_gen_stall_mask_gen.sv | 24 ++
 rtl/pipeline_ctrl_gen.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_gen_pkg.sv
// Shared definitions for the pipeline controller.
//  - exception codes (interrupt, ERET) and the register bus width
//  - controller state encoding
//  - watchdog saturation value (used when PIPE_CTRL_WDOG_EN is defined)
//  - sel_target(): maps an exception code to its redirect PC
package pipeline_ctrl_gen_pkg;

  localparam int unsigned REG_W = 32;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  localparam logic [15:0] PCTL_WDOG_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    PCTL_RUN   = 2'd0,
    PCTL_HOLD  = 2'd1,
    PCTL_FLUSH = 2'd2
  } pctl_state_e;

  // Interrupt -> int_vec, ERET -> epc, any other code -> exc_vec.
  // Unknown codes deliberately fall through to exc_vec.
  function automatic logic [REG_W-1:0] sel_target(
    input logic [31:0]      code,
    input logic [REG_W-1:0] epc,
    input logic [REG_W-1:0] int_vec,
    input logic [REG_W-1:0] exc_vec
  );
    if (code == EXC_INT)       return int_vec;
    else if (code == EXC_ERET) return epc;
    else                       return exc_vec;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_gen_if.sv
// Pipeline <-> controller signal bundle.
//  master : pipeline side, drives stall requests, exception code and EPC;
//           receives stall vector, flush, redirect PC and busy.
//  slave  : controller side (pipeline_ctrl_gen).
interface pipeline_ctrl_gen_if
  import pipeline_ctrl_gen_pkg::*;
#(
  parameter int unsigned NSTAGE = 6
) ();

  logic [NSTAGE-1:0] stallreq_i;
  logic [31:0]       excepttype_i;
  logic [REG_W-1:0]  cp0_epc_i;
  logic [NSTAGE-1:0] stall;
  logic              flush;
  logic [REG_W-1:0]  new_pc;
  logic              busy_o;

  modport master (
    output stallreq_i, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, busy_o
  );

  modport slave (
    input  stallreq_i, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, busy_o
  );

endinterface

// File: rtl/pipeline_ctrl_gen_stall_mask_gen.sv
// stall_mask_gen: priority encoder + thermometer mask, purely combinational.
//  req  in  NSTAGE  per-stage stall requests
//  mask out NSTAGE  bits 0..K set, K = highest set bit of req; 0 if none
module stall_mask_gen #(
  parameter int unsigned NSTAGE = 6
) (
  input  logic [NSTAGE-1:0] req,
  output logic [NSTAGE-1:0] mask
);

  logic acc;

  // Running OR from the top stage down: every stage at or below the
  // highest requester is frozen.
  always_comb begin
    acc  = 1'b0;
    mask = '0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      acc                  = acc | req[NSTAGE-1-i];
      mask[NSTAGE-1-i]     = acc;
    end
  end

endmodule

// File: rtl/pipeline_ctrl_gen.sv
// pipeline_ctrl_gen: pipeline stall/flush controller.
//  Merges stage stall requests into a thermometer stall vector and turns
//  MEM exceptions into flush + redirect PC. An exception arriving during an
//  in-flight MEM stall is held (HOLD) until the bus access completes; flush
//  is stretched over FLUSH_CYC cycles (FLUSH).
// Ports:
//  clk            in   rising-edge clock
//  rst            in   asynchronous reset, active-low
//  bus            slave modport: stallreq_i, excepttype_i, cp0_epc_i in;
//                 stall, flush, new_pc, busy_o out
//  wdog_timeout_o out  only with `PIPE_CTRL_WDOG_EN: one-cycle pulse when a
//                 stall has persisted 65535 cycles
// Optional feature macro: PIPE_CTRL_WDOG_EN
module pipeline_ctrl_gen
  import pipeline_ctrl_gen_pkg::*;
#(
  parameter int unsigned      NSTAGE    = 6,
  parameter int unsigned      MEM_STAGE = 4,
  parameter int unsigned      FLUSH_CYC = 1,
  parameter logic [REG_W-1:0] INT_VEC   = 32'h0000_0020,
  parameter logic [REG_W-1:0] EXC_VEC   = 32'h0000_0040
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_ctrl_gen_if.slave   bus
`ifdef PIPE_CTRL_WDOG_EN
  ,
  output logic                 wdog_timeout_o
`endif
);

  localparam int unsigned CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [NSTAGE-1:0] MEM_MASK =
    NSTAGE'((64'd1 << (MEM_STAGE + 1)) - 64'd1);

  pctl_state_e       state;
  logic [31:0]       code_q;
  logic [REG_W-1:0]  epc_q;
  logic [REG_W-1:0]  target_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [NSTAGE-1:0] mask;
  logic              exc_now;
  logic              mem_busy;
  logic [REG_W-1:0]  run_target;
  logic [REG_W-1:0]  hold_target;

  stall_mask_gen #(.NSTAGE(NSTAGE)) u_mask (
    .req  (bus.stallreq_i),
    .mask (mask)
  );

  assign exc_now     = (bus.excepttype_i != '0);
  assign mem_busy    = bus.stallreq_i[MEM_STAGE];
  assign run_target  = sel_target(bus.excepttype_i, bus.cp0_epc_i, INT_VEC, EXC_VEC);
  // Deferred exception resolves from the values captured when it arrived.
  assign hold_target = sel_target(code_q, epc_q, INT_VEC, EXC_VEC);

  // Outputs are combinational so an exception in RUN flushes with zero
  // latency; the reset term forces all outputs low while rst is asserted.
  always_comb begin
    bus.stall  = mask;
    bus.flush  = 1'b0;
    bus.new_pc = '0;
    if (!rst) begin
      bus.stall = '0;
    end else begin
      unique case (state)
        PCTL_RUN: begin
          if (exc_now && !mem_busy) begin
            bus.flush  = 1'b1;
            bus.stall  = '0;
            bus.new_pc = run_target;
          end
        end
        PCTL_HOLD: begin
          if (mem_busy) begin
            bus.stall = mask | MEM_MASK;
          end else begin
            bus.flush  = 1'b1;
            bus.stall  = '0;
            bus.new_pc = hold_target;
          end
        end
        PCTL_FLUSH: begin
          bus.flush  = 1'b1;
          bus.stall  = '0;
          bus.new_pc = target_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o = rst && (state != PCTL_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PCTL_RUN;
      code_q   <= '0;
      epc_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state)
        PCTL_RUN: begin
          if (exc_now) begin
            code_q <= bus.excepttype_i;
            if (mem_busy) begin
              epc_q <= bus.cp0_epc_i;
              state <= PCTL_HOLD;
            end else begin
              target_q <= run_target;
              if (FLUSH_CYC > 1) begin
                cnt_q <= CNT_W'(FLUSH_CYC - 1);
                state <= PCTL_FLUSH;
              end
            end
          end
        end
        PCTL_HOLD: begin
          if (!mem_busy) begin
            target_q <= hold_target;
            if (FLUSH_CYC > 1) begin
              cnt_q <= CNT_W'(FLUSH_CYC - 1);
              state <= PCTL_FLUSH;
            end else begin
              state <= PCTL_RUN;
            end
          end
        end
        PCTL_FLUSH: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) state <= PCTL_RUN;
        end
        default: state <= PCTL_RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_WDOG_EN
  logic [15:0] wcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt           <= '0;
      wdog_timeout_o <= 1'b0;
    end else begin
      wdog_timeout_o <= 1'b0;
      if (bus.stall == '0 || bus.flush) begin
        wcnt <= '0;
      end else if (wcnt != PCTL_WDOG_MAX) begin
        wcnt <= wcnt + 16'd1;
        // Pulse on the cycle the counter reaches its ceiling, then hold there.
        if (wcnt == PCTL_WDOG_MAX - 16'd1) wdog_timeout_o <= 1'b1;
      end
    end
  end
`endif

endmodule
